pkt_fifo_store_forward: RTL
===========================

# pkt_fifo_store_forward

Store-and-forward byte-stream packet FIFO that sits directly upstream of each input of the round-robin scheduler. It accepts an 8-bit AXI-Stream-style frame and presents it downstream only after the whole frame (through `tlast`) has been written. The scheduler therefore never waits on a half-arrived frame and never locks its grant mid-packet. Frames that overflow the buffer are discarded whole, and the discard is reported.

## Interface
Parameters:
- `ADDR_WIDTH`, 11, log2 of buffer depth; capacity is 2^ADDR_WIDTH bytes in RAM plus 1 in the output register.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `tdata_i`  in  8  ingress byte.
- `tvalid_i`  in  1  ingress byte valid.
- `tlast_i`  in  1  ingress last byte of frame.
- `tready_i`  out  1  ingress ready; 1 whenever not in reset; the block never back-pressures and drops instead.
- `tdata_o`  out  8  egress byte, to scheduler `tdata_i_N`.
- `tvalid_o`  out  1  egress valid.
- `tlast_o`  out  1  egress last byte.
- `tready_o`  in  1  egress ready, from scheduler `tready_i_N`.
- `drop_o`  out  1  one-cycle pulse per discarded frame.
- `drop_cnt_o`  out  16  saturating dropped-frame count (see Configuration).

## Operation
- Storage is a 2^ADDR_WIDTH x 9 RAM holding `{tlast, tdata}`.
- Pointers are ADDR_WIDTH+1 bits:
  - `wr_ptr`: next write.
  - `cm_ptr`: commit, i.e. end of last complete frame.
  - `rd_ptr`: next read.
- RAM full when `wr_ptr - rd_ptr == 2^ADDR_WIDTH`.
- Write FSM, states `ACCEPT` and `DROP`:
  - ACCEPT, beat accepted, not full: write RAM[wr_ptr], `wr_ptr++`. If `tlast_i`, `cm_ptr <= wr_ptr+1`.
  - ACCEPT, beat accepted, full: `wr_ptr <= cm_ptr`, pulse `drop_o`. Go to DROP unless `tlast_i`, in which case stay in ACCEPT.
  - DROP: discard every beat. On a `tlast_i` beat, return to ACCEPT. No further `drop_o` for the same frame.
- A frame longer than total capacity is always dropped. Earlier committed frames are never corrupted.
- Read side has a single output register (`tvalid_o`, `tdata_o`, `tlast_o`):
  - Load when (`!tvalid_o` or `tready_o`) and `rd_ptr != cm_ptr`, then `rd_ptr++`.
  - Clear `tvalid_o` when `tready_o` and nothing is loadable.
- Uncommitted bytes are never readable.
- Output is held stable while `tvalid_o && !tready_o`.
- Simultaneous commit and read, and simultaneous write and read, are both legal. Full is evaluated with `rd_ptr` before this cycle's read, so a slot freed this cycle is usable next cycle.

## Timing
- Reset values (asserted asynchronously while `rst`=0):
  - All pointers 0, FSM = ACCEPT.
  - `tvalid_o`=0, `tdata_o`=0, `tlast_o`=0.
  - `tready_i`=0, `drop_o`=0, `drop_cnt_o`=0.
- Deassertion is synchronised internally. `tready_i` rises on the first edge after release.
- Latency: `tlast` beat accepted at edge E, commit at E. The first byte of that frame is loaded at E+1 if the output register is free, so `tvalid_o`=1 in the cycle after E+1.
- Throughput is 1 byte/cycle on both sides. Back-to-back frames egress with no idle cycle if the next frame is already committed.
- `drop_o` is high for exactly the cycle after the overflowing beat's edge.
- Reset mid-frame discards all stored and in-flight data.

## Configuration
- `PKT_FIFO_DROP_CNT_EN` defined:
  - `drop_cnt_o` increments on each `drop_o` pulse.
  - It saturates at 16'hFFFF and clears only by reset.
- Not defined: counter logic is removed and `drop_cnt_o` is tied to 16'h0000. `drop_o` is still generated.

## Test plan
- Reset release, then one 64-byte frame (bytes 0x00..0x3F) with `tready_o`=1:
  - `tvalid_o` stays 0 until 2 cycles after `tlast_i`.
  - Then 64 consecutive bytes 0x00..0x3F, with `tlast_o` only on 0x3F.
- 1-byte frame (0xA5, `tlast`=1): exactly one egress beat, 0xA5 with `tlast_o`=1.
- ADDR_WIDTH=4, `tready_o`=0, 20-byte frame:
  - One `drop_o` pulse on the 17th byte.
  - Later `tready_o`=1 yields no egress.
  - `drop_cnt_o`=1 with macro, 0 without.
- ADDR_WIDTH=4:
  - Store a 10-byte frame, then send a 10-byte frame with `tready_o`=0: the second is dropped.
  - First frame egresses intact once `tready_o`=1.
  - A third 6-byte frame then passes.
- Random `tready_o` stall pattern over 100 frames of random length 1..200, ADDR_WIDTH=11: output byte sequence equals input, no drops.
- Assert `rst`=0 mid-frame during egress: outputs go to reset values immediately. After release, the next frame passes cleanly.

Source files
------------

// File: rtl/pkt_fifo_store_forward.sv
// pkt_fifo_store_forward
// Store-and-forward byte-stream packet FIFO. A frame becomes visible on the
// egress side only after its tlast beat has been written. Frames that do not
// fit are discarded whole and reported with a one-cycle drop_o pulse.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous active-low reset (release synchronised internally)
//   tdata_i    - ingress byte
//   tvalid_i   - ingress byte valid
//   tlast_i    - ingress last byte of frame
//   tready_i   - ingress ready (output), high whenever out of reset
//   tdata_o    - egress byte
//   tvalid_o   - egress valid
//   tlast_o    - egress last byte
//   tready_o   - egress ready (input)
//   drop_o     - one-cycle pulse per discarded frame
//   drop_cnt_o - saturating dropped-frame count
//
// Build option: define PKT_FIFO_DROP_CNT_EN to enable the drop counter;
// otherwise drop_cnt_o is tied to zero.
module pkt_fifo_store_forward #(
    parameter int unsigned ADDR_WIDTH = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  tdata_i,
    input  logic        tvalid_i,
    input  logic        tlast_i,
    output logic        tready_i,
    output logic [7:0]  tdata_o,
    output logic        tvalid_o,
    output logic        tlast_o,
    input  logic        tready_o,
    output logic        drop_o,
    output logic [15:0] drop_cnt_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic {
        ACCEPT = 1'b0,
        DROP   = 1'b1
    } wr_state_e;

    // Assertion is asynchronous; release takes effect on the first edge after rst rises.
    logic rst_sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= 1'b0;
        else      rst_sync_q <= 1'b1;
    end

    assign tready_i = rst_sync_q;

    logic [8:0]          mem [DEPTH];
    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] cm_ptr_q, cm_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q;
    logic [ADDR_WIDTH:0] used;
    wr_state_e           state_q, state_d;
    logic                beat, full, wr_en;
    logic                drop_q, drop_d;
    logic                tvalid_q, tlast_q;
    logic [7:0]          tdata_q;
    logic                load;

    assign beat = tvalid_i & rst_sync_q;
    assign used = wr_ptr_q - rd_ptr_q;
    // Occupancy never exceeds DEPTH, so the MSB alone marks full.
    assign full = used[ADDR_WIDTH];

    // Write FSM: state register
    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) state_q <= ACCEPT;
        else             state_q <= state_d;
    end

    // Write FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCEPT:  if (beat && full && !tlast_i) state_d = DROP;
            DROP:    if (beat && tlast_i)          state_d = ACCEPT;
            default: state_d = ACCEPT;
        endcase
    end

    // Write FSM: outputs (RAM write, pointer updates, drop pulse)
    always_comb begin
        wr_en    = 1'b0;
        wr_ptr_d = wr_ptr_q;
        cm_ptr_d = cm_ptr_q;
        drop_d   = 1'b0;
        if (state_q == ACCEPT && beat) begin
            if (full) begin
                // Rewind to the last complete frame; committed data is untouched.
                wr_ptr_d = cm_ptr_q;
                drop_d   = 1'b1;
            end else begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                if (tlast_i) cm_ptr_d = wr_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {tlast_i, tdata_i};
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            wr_ptr_q <= '0;
            cm_ptr_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            cm_ptr_q <= cm_ptr_d;
            drop_q   <= drop_d;
        end
    end

    // Read side: single output register fed only from committed bytes.
    assign load = (!tvalid_q || tready_o) && (rd_ptr_q != cm_ptr_q);

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            rd_ptr_q <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
        end else if (load) begin
            rd_ptr_q           <= rd_ptr_q + PTR_ONE;
            {tlast_q, tdata_q} <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
            tvalid_q           <= 1'b1;
        end else if (tready_o) begin
            tvalid_q <= 1'b0;
        end
    end

    assign tvalid_o = tvalid_q;
    assign tdata_o  = tdata_q;
    assign tlast_o  = tlast_q;
    assign drop_o   = drop_q;

`ifdef PKT_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q)                          drop_cnt_q <= '0;
        else if (drop_q && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    assign drop_cnt_o = '0;
`endif

endmodule
